// File: rtl/riscv_pkg.sv
// RV32I decode definitions: opcodes, immediate formats, control enums and the ID/EX control bundle.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_REG      = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_U     = 3'd3,
        IMM_J     = 3'd4,
        IMM_SHAMT = 3'd5
    } imm_src_e;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'b00,
        SRC_A_PC   = 2'b01,
        SRC_A_ZERO = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic        reg_wr_en;
        logic        mem_wr_en;
        logic        mem_rd_en;
        alu_src_a_e  alu_src_a;
        logic        alu_src_b;
        alu_op_e     alu_op;
        result_src_e result_src;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: selects the RV32I immediate format and sign-extends it to XLEN.
// Purely combinational, no handshake.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  imm_src_e        imm_src_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
        case (imm_src_i)
            IMM_S:     imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:     imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:     imm32 = {instr_i[31:12], 12'b0};
            IMM_J:     imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                instr_i[20], instr_i[30:21], 1'b0};
            IMM_SHAMT: imm32 = {27'b0, instr_i[24:20]};
            default:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
        endcase
    end

    // shamt has bit 31 clear, so the uniform sign extension keeps it zero-extended
    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I ID stage: decode + immediate into an ID/EX register, 1 cycle accept-to-valid.
// Backpressure: holds outputs while out_ready_i=0; in_ready_o drops on flush, full-and-blocked, or load-use hazard.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit HAZARD_EN  = 1'b1,
    parameter bit SYS_AS_NOP = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      funct3_o,
    output logic            funct7b5_o,
    output logic            reg_wr_en_o,
    output logic            mem_wr_en_o,
    output logic            mem_rd_en_o,
    output logic [1:0]      alu_src_a_o,
    output logic            alu_src_b_o,
    output logic [1:0]      alu_op_o,
    output logic [1:0]      result_src_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic            jalr_o,
    output logic            illegal_o
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FULL    = 2'd1;
    localparam logic [1:0] ST_FULL_LD = 2'd2;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd, rs1, rs2;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];

    ctrl_t           ctrl_d, ctrl_q;
    imm_src_e        imm_src;
    logic            uses_rs1, uses_rs2, illegal;
    logic [XLEN-1:0] imm_d, imm_q, pc_q;
    logic [4:0]      rd_q, rs1_q, rs2_q;
    logic [2:0]      funct3_q;
    logic            funct7b5_q;
    logic [1:0]      state_d, state_q;
    logic            stall, accept, consume, load_wr;

    always_comb begin
        ctrl_d   = '0;
        imm_src  = IMM_I;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_LOAD: begin
                ctrl_d.reg_wr_en  = 1'b1;
                ctrl_d.mem_rd_en  = 1'b1;
                ctrl_d.alu_src_b  = 1'b1;
                ctrl_d.result_src = RES_MEM;
                illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OP_IMM: begin
                ctrl_d.reg_wr_en = 1'b1;
                ctrl_d.alu_src_b = 1'b1;
                ctrl_d.alu_op    = ALU_FUNCT;
                if (funct3 == 3'b001) begin
                    imm_src = IMM_SHAMT;
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    imm_src = IMM_SHAMT;
                    illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end
            end
            OP_STORE: begin
                ctrl_d.mem_wr_en = 1'b1;
                ctrl_d.alu_src_b = 1'b1;
                imm_src  = IMM_S;
                uses_rs2 = 1'b1;
                illegal  = (funct3 >= 3'd3);
            end
            OP_REG: begin
                ctrl_d.reg_wr_en = 1'b1;
                ctrl_d.alu_op    = ALU_FUNCT;
                uses_rs2 = 1'b1;
                // only SUB and SRA carry funct7=0100000
                if (funct7 == 7'b0100000)
                    illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
                else
                    illegal = (funct7 != 7'b0000000);
            end
            OP_BRANCH: begin
                ctrl_d.branch = 1'b1;
                ctrl_d.alu_op = ALU_BRANCH;
                imm_src  = IMM_B;
                uses_rs2 = 1'b1;
                illegal  = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OP_JAL: begin
                ctrl_d.jump       = 1'b1;
                ctrl_d.reg_wr_en  = 1'b1;
                ctrl_d.result_src = RES_PC4;
                ctrl_d.alu_src_a  = SRC_A_PC;
                ctrl_d.alu_src_b  = 1'b1;
                imm_src  = IMM_J;
                uses_rs1 = 1'b0;
            end
            OP_JALR: begin
                ctrl_d.jump       = 1'b1;
                ctrl_d.jalr       = 1'b1;
                ctrl_d.reg_wr_en  = 1'b1;
                ctrl_d.result_src = RES_PC4;
                ctrl_d.alu_src_b  = 1'b1;
                illegal = (funct3 != 3'b000);
            end
            OP_LUI: begin
                ctrl_d.alu_src_a = SRC_A_ZERO;
                ctrl_d.alu_src_b = 1'b1;
                ctrl_d.reg_wr_en = 1'b1;
                imm_src  = IMM_U;
                uses_rs1 = 1'b0;
            end
            OP_AUIPC: begin
                ctrl_d.alu_src_a = SRC_A_PC;
                ctrl_d.alu_src_b = 1'b1;
                ctrl_d.reg_wr_en = 1'b1;
                imm_src  = IMM_U;
                uses_rs1 = 1'b0;
            end
            OP_MISC_MEM, OP_SYSTEM: illegal = !SYS_AS_NOP;
            default:                illegal = 1'b1;
        endcase
        if (instr_i[1:0] != 2'b11)
            illegal = 1'b1;
        if (illegal) begin
            ctrl_d.reg_wr_en = 1'b0;
            ctrl_d.mem_wr_en = 1'b0;
            ctrl_d.mem_rd_en = 1'b0;
            ctrl_d.branch    = 1'b0;
            ctrl_d.jump      = 1'b0;
            ctrl_d.jalr      = 1'b0;
        end
        ctrl_d.illegal = illegal;
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i   (instr_i),
        .imm_src_i (imm_src),
        .imm_o     (imm_d)
    );

    // FULL_LD is only entered for rd!=0, so x0 never interlocks
    assign stall = HAZARD_EN && (state_q == ST_FULL_LD) && (rd_q != 5'd0) &&
                   ((uses_rs1 && (rs1 == rd_q)) || (uses_rs2 && (rs2 == rd_q)));

    assign out_valid_o = (state_q != ST_EMPTY);
    assign in_ready_o  = !flush_i && (!out_valid_o || out_ready_i) && !stall;
    assign accept      = in_valid_i && in_ready_o;
    assign consume     = out_valid_o && out_ready_i;
    assign load_wr     = ctrl_d.mem_rd_en && (rd != 5'd0);

    always_comb begin
        state_d = state_q;
        if (flush_i)
            state_d = ST_EMPTY;
        else if (accept)
            state_d = load_wr ? ST_FULL_LD : ST_FULL;
        else if (consume)
            state_d = ST_EMPTY;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_EMPTY;
            pc_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pc_q       <= pc_i;
                rd_q       <= rd;
                rs1_q      <= rs1;
                rs2_q      <= rs2;
                imm_q      <= imm_d;
                funct3_q   <= funct3;
                funct7b5_q <= instr_i[30];
                ctrl_q     <= ctrl_d;
            end
        end
    end

    assign out_pc_o     = pc_q;
    assign rd_o         = rd_q;
    assign rs1_o        = rs1_q;
    assign rs2_o        = rs2_q;
    assign imm_o        = imm_q;
    assign funct3_o     = funct3_q;
    assign funct7b5_o   = funct7b5_q;
    assign reg_wr_en_o  = ctrl_q.reg_wr_en;
    assign mem_wr_en_o  = ctrl_q.mem_wr_en;
    assign mem_rd_en_o  = ctrl_q.mem_rd_en;
    assign alu_src_a_o  = ctrl_q.alu_src_a;
    assign alu_src_b_o  = ctrl_q.alu_src_b;
    assign alu_op_o     = ctrl_q.alu_op;
    assign result_src_o = ctrl_q.result_src;
    assign branch_o     = ctrl_q.branch;
    assign jump_o       = ctrl_q.jump;
    assign jalr_o       = ctrl_q.jalr;
    assign illegal_o    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default instance plus a HAZARD_EN=0 / SYS_AS_NOP=0 instance on shared stimulus.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] instr, pc;

    logic        in_ready, out_valid, f7b5, reg_wr, mem_wr, mem_rd, src_b, br, jmp, jalr, ill;
    logic [31:0] out_pc, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [1:0]  src_a, alu_op, res_src;

    logic        a_in_ready, a_out_valid, a_f7b5, a_reg_wr, a_mem_wr, a_mem_rd, a_src_b, a_br, a_jmp, a_jalr, a_ill;
    logic [31:0] a_out_pc, a_imm;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_f3;
    logic [1:0]  a_src_a, a_alu_op, a_res_src;

    logic [13:0] ctrl_w, a_ctrl_w;
    assign ctrl_w   = {reg_wr, mem_wr, mem_rd, src_a, src_b, alu_op, res_src, br, jmp, jalr, ill};
    assign a_ctrl_w = {a_reg_wr, a_mem_wr, a_mem_rd, a_src_a, a_src_b, a_alu_op, a_res_src,
                       a_br, a_jmp, a_jalr, a_ill};

    always #5 clk = ~clk;

    decode_stage dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_pc_o(out_pc), .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2), .imm_o(imm), .funct3_o(f3),
        .funct7b5_o(f7b5), .reg_wr_en_o(reg_wr), .mem_wr_en_o(mem_wr), .mem_rd_en_o(mem_rd),
        .alu_src_a_o(src_a), .alu_src_b_o(src_b), .alu_op_o(alu_op), .result_src_o(res_src),
        .branch_o(br), .jump_o(jmp), .jalr_o(jalr), .illegal_o(ill)
    );

    decode_stage #(.HAZARD_EN(1'b0), .SYS_AS_NOP(1'b0)) dut_alt (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
        .instr_i(instr), .pc_i(pc), .out_valid_o(a_out_valid), .out_ready_i(out_ready),
        .out_pc_o(a_out_pc), .rd_o(a_rd), .rs1_o(a_rs1), .rs2_o(a_rs2), .imm_o(a_imm), .funct3_o(a_f3),
        .funct7b5_o(a_f7b5), .reg_wr_en_o(a_reg_wr), .mem_wr_en_o(a_mem_wr), .mem_rd_en_o(a_mem_rd),
        .alu_src_a_o(a_src_a), .alu_src_b_o(a_src_b), .alu_op_o(a_alu_op), .result_src_o(a_res_src),
        .branch_o(a_br), .jump_o(a_jmp), .jalr_o(a_jalr), .illegal_o(a_ill)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_pc"}, out_pc, 32'd0);
        chk({tag, "_imm"}, imm, 32'd0);
        chk({tag, "_fields"}, {13'b0, rd, rs1, rs2, f3, f7b5}, 32'd0);
        chk({tag, "_ctrl"}, {18'b0, ctrl_w}, 32'd0);
        chk({tag, "_alt_valid"}, {31'b0, a_out_valid}, 32'd0);
        chk({tag, "_alt_pc_imm"}, a_out_pc | a_imm, 32'd0);
        chk({tag, "_alt_fields"}, {13'b0, a_rd, a_rs1, a_rs2, a_f3, a_f7b5}, 32'd0);
        chk({tag, "_alt_ctrl"}, {18'b0, a_ctrl_w}, 32'd0);
    endtask

    // ctrl layout: reg_wr mem_wr mem_rd src_a[2] src_b alu_op[2] result[2] branch jump jalr illegal
    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        chk_imm;
        logic [31:0] imm;
        logic [13:0] ctrl;
        logic [13:0] mask;
        logic        alt_ill;
    } vec_t;

    localparam int NV = 16;
    localparam logic [13:0] ALL = 14'h3FFF;
    localparam logic [13:0] ENM = 14'b1_1_1_00_0_00_00_1_1_0_1;

    localparam logic [31:0] LW_X5  = 32'h00012283;
    localparam logic [31:0] LW_X0  = 32'h00012003;
    localparam logic [31:0] ADD_65 = 32'h00128333;
    localparam logic [31:0] ADD_60 = 32'h00100333;
    localparam logic [31:0] BEQ    = 32'hFE208EE3;
    localparam logic [31:0] ADDI   = 32'h00500093;

    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{ADDI,         5'd1,  1'b1, 32'h00000005, 14'b1_0_0_00_1_10_00_0_0_0_0, ALL, 1'b0};
        vecs[1]  = '{LW_X5,        5'd5,  1'b1, 32'h00000000, 14'b1_0_1_00_1_00_01_0_0_0_0, ALL, 1'b0};
        vecs[2]  = '{32'h123453B7, 5'd7,  1'b1, 32'h12345000, 14'b1_0_0_10_1_00_00_0_0_0_0, ALL, 1'b0};
        vecs[3]  = '{32'h00612423, 5'd8,  1'b1, 32'h00000008, 14'b0_1_0_00_1_00_00_0_0_0_0, ALL, 1'b0};
        vecs[4]  = '{32'h402081B3, 5'd3,  1'b0, 32'h00000000, 14'b1_0_0_00_0_10_00_0_0_0_0, ALL, 1'b0};
        vecs[5]  = '{BEQ,          5'd29, 1'b1, 32'hFFFFFFFC, 14'b0_0_0_00_0_01_00_1_0_0_0, ALL, 1'b0};
        vecs[6]  = '{32'h008000EF, 5'd1,  1'b1, 32'h00000008, 14'b1_0_0_01_1_00_10_0_1_0_0, ALL, 1'b0};
        vecs[7]  = '{32'h00008067, 5'd0,  1'b1, 32'h00000000, 14'b1_0_0_00_1_00_10_0_1_1_0, ALL, 1'b0};
        vecs[8]  = '{32'hFFFFF217, 5'd4,  1'b1, 32'hFFFFF000, 14'b1_0_0_01_1_00_00_0_0_0_0, ALL, 1'b0};
        vecs[9]  = '{32'h4030D293, 5'd5,  1'b1, 32'h00000003, 14'b1_0_0_00_1_10_00_0_0_0_0, ALL, 1'b0};
        vecs[10] = '{32'h0000007F, 5'd0,  1'b0, 32'h00000000, 14'b0_0_0_00_0_00_00_0_0_0_1, ENM, 1'b1};
        vecs[11] = '{32'h402091B3, 5'd3,  1'b0, 32'h00000000, 14'b0_0_0_00_0_00_00_0_0_0_1, ENM, 1'b1};
        vecs[12] = '{32'h00000073, 5'd0,  1'b0, 32'h00000000, 14'b0_0_0_00_0_00_00_0_0_0_0, ALL, 1'b1};
        vecs[13] = '{32'h00013283, 5'd5,  1'b0, 32'h00000000, 14'b0_0_0_00_0_00_00_0_0_0_1, ENM, 1'b1};
        vecs[14] = '{32'h40109093, 5'd1,  1'b0, 32'h00000000, 14'b0_0_0_00_0_00_00_0_0_0_1, ENM, 1'b1};
        vecs[15] = '{32'h00500090, 5'd1,  1'b0, 32'h00000000, 14'b0_0_0_00_0_00_00_0_0_0_1, ENM, 1'b1};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0; pc = '0;
        tick();
        tick();
        chk_zero("reset");
        rst_n = 1'b1;
        out_ready = 1'b1;

        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            instr = vecs[i].instr;
            pc = 32'h100 + 32'(4 * i);
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
            tick();
            chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("v%0d_pc", i), out_pc, 32'h100 + 32'(4 * i));
            chk($sformatf("v%0d_rd", i), {27'b0, rd}, {27'b0, vecs[i].rd});
            chk($sformatf("v%0d_ctrl", i), {18'b0, ctrl_w & vecs[i].mask},
                {18'b0, vecs[i].ctrl & vecs[i].mask});
            if (vecs[i].chk_imm)
                chk($sformatf("v%0d_imm", i), imm, vecs[i].imm);
            chk($sformatf("v%0d_alt_illegal", i), {31'b0, a_ill}, {31'b0, vecs[i].alt_ill});
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // branch held under backpressure, then a single consume
        in_valid = 1'b1; instr = BEQ; pc = 32'h200;
        tick();
        out_ready = 1'b0; instr = ADDI; pc = 32'h204;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold%0d_in_ready", k), {31'b0, in_ready}, 32'd0);
            chk($sformatf("hold%0d_valid", k), {31'b0, out_valid}, 32'd1);
            chk($sformatf("hold%0d_imm", k), imm, 32'hFFFFFFFC);
            chk($sformatf("hold%0d_pc", k), out_pc, 32'h200);
            chk($sformatf("hold%0d_branch", k), {31'b0, br}, 32'd1);
            tick();
        end
        out_ready = 1'b1; in_valid = 1'b0;
        tick();
        chk("hold_release_valid", {31'b0, out_valid}, 32'd0);

        // load-use: one bubble with interlock, none without
        in_valid = 1'b1; instr = LW_X5; pc = 32'h300;
        tick();
        chk("lu_lw_valid", {31'b0, out_valid}, 32'd1);
        instr = ADD_65; pc = 32'h304;
        #1;
        chk("lu_stall_ready", {31'b0, in_ready}, 32'd0);
        chk("lu_alt_ready", {31'b0, a_in_ready}, 32'd1);
        tick();
        chk("lu_bubble", {31'b0, out_valid}, 32'd0);
        chk("lu_alt_add_valid", {31'b0, a_out_valid}, 32'd1);
        chk("lu_alt_add_rd", {27'b0, a_rd}, 32'd6);
        #1;
        chk("lu_after_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("lu_add_valid", {31'b0, out_valid}, 32'd1);
        chk("lu_add_rd", {27'b0, rd}, 32'd6);
        chk("lu_add_pc", out_pc, 32'h304);
        in_valid = 1'b0;
        tick();
        tick();

        // load to x0 never interlocks
        in_valid = 1'b1; instr = LW_X0; pc = 32'h400;
        tick();
        instr = ADD_60; pc = 32'h404;
        #1;
        chk("x0_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("x0_add_valid", {31'b0, out_valid}, 32'd1);
        chk("x0_add_rd", {27'b0, rd}, 32'd6);
        in_valid = 1'b0;
        tick();

        // flush during FULL_LD with a stalled dependent
        in_valid = 1'b1; instr = LW_X5; pc = 32'h500;
        tick();
        instr = ADD_65; pc = 32'h504; flush = 1'b1;
        #1;
        chk("flush_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        #1;
        chk("flush_dep_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("flush_dep_valid", {31'b0, out_valid}, 32'd1);
        chk("flush_dep_pc", out_pc, 32'h504);

        // reset in the middle of a stream
        instr = ADDI; pc = 32'h600;
        tick();
        chk("mid_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk_zero("mid_reset");
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        chk("post_reset_valid", {31'b0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
